// File: rtl/deploy_pkg.sv
// Shared types, card costs and screen geometry for the card/elixir front end.
package deploy_pkg;

  localparam int NUM_UNITS     = 3;
  localparam int START_ELIXIR  = 5;
  localparam int MAX_ELIXIR    = 10;
  localparam int ELIXIR_FRAMES = 60;

  typedef enum logic [1:0] {IDLE, HOLD, DEPLOY} fsm_t;
  typedef enum logic [1:0] {FREE_PEND, FREE, BUSY} slot_t;

  localparam logic [3:0] COST    [NUM_UNITS] = '{4'd3, 4'd3, 4'd4};
  localparam logic [9:0] CARD_Y0 [NUM_UNITS] = '{10'd137, 10'd217, 10'd297};

  localparam logic [9:0] CARD_X0  = 10'd570;
  localparam logic [9:0] CARD_X1  = 10'd601;
  localparam logic [9:0] CARD_H   = 10'd63;
  localparam logic [9:0] FIELD_X0 = 10'd20;
  localparam logic [9:0] FIELD_X1 = 10'd549;
  localparam logic [9:0] FIELD_Y0 = 10'd31;
  localparam logic [9:0] FIELD_Y1 = 10'd448;

  function automatic logic [NUM_UNITS-1:0] unit_mask(input logic [1:0] idx);
    return NUM_UNITS'(1) << idx;
  endfunction

endpackage

// File: rtl/elixir_bank.sv
// Elixir accumulator: +1 every ELIXIR_FRAMES frame ticks, saturating, with a spend port.
module elixir_bank
  import deploy_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       spend_en,
  input  logic [3:0] cost,
  output logic [3:0] elixir
);

  logic [5:0] frame_cnt;
  logic       wrap;
  logic [4:0] sum;

  assign wrap = frame_tick && (frame_cnt == 6'(ELIXIR_FRAMES - 1));

  // Spends are only issued when affordable, so the 5-bit sum never goes negative.
  always_comb begin
    sum = {1'b0, elixir} + {4'b0, wrap};
    if (spend_en) sum = sum - {1'b0, cost};
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      elixir    <= 4'(START_ELIXIR);
    end else begin
      if (frame_tick) frame_cnt <= wrap ? 6'd0 : frame_cnt + 6'd1;
      elixir <= (sum > 5'(MAX_ELIXIR)) ? 4'(MAX_ELIXIR) : sum[3:0];
    end
  end

endmodule

// File: rtl/deploy_ctrl.sv
// Card column front end: click select -> field place -> deploy for one vsync, with per-slot re-arm.
module deploy_ctrl
  import deploy_pkg::*;
(
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic [9:0]           MouseX,
  input  logic [9:0]           MouseY,
  input  logic [1:0]           button,
  input  logic [NUM_UNITS-1:0] infield,
  input  logic                 game_over,
  output logic [NUM_UNITS-1:0] idleout,
  output logic [NUM_UNITS-1:0] instateout,
  output logic [NUM_UNITS-1:0] deployout,
  output logic [3:0]           elixir,
  output logic                 sel_valid,
  output logic [1:0]           sel_idx
);

  fsm_t                 fsm;
  slot_t                slot [NUM_UNITS];
  logic                 vsync_q;
  logic [1:0]           btn_q;
  logic [NUM_UNITS-1:0] infield_q;
  logic                 frame_tick, lclick, rclick;
  logic [NUM_UNITS-1:0] hit_card, fall;
  logic                 hit_field, card_hit, card_ok, spend_en, cancel;
  logic [1:0]           card_idx;

  assign frame_tick = vsync & ~vsync_q;
  assign lclick     = button[0] & ~btn_q[0];
  assign rclick     = button[1] & ~btn_q[1];
  assign fall       = infield_q & ~infield;
  assign hit_field  = (MouseX >= FIELD_X0) && (MouseX <= FIELD_X1) &&
                      (MouseY >= FIELD_Y0) && (MouseY <= FIELD_Y1);

  // Card hitboxes are disjoint, so at most one index can match.
  always_comb begin
    card_hit = 1'b0;
    card_ok  = 1'b0;
    card_idx = 2'd0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      hit_card[i] = (MouseX >= CARD_X0) && (MouseX <= CARD_X1) &&
                    (MouseY >= CARD_Y0[i]) && (MouseY <= CARD_Y0[i] + CARD_H);
      idleout[i]  = (slot[i] == FREE_PEND);
      if (hit_card[i]) begin
        card_hit = 1'b1;
        card_idx = 2'(i);
        card_ok  = (slot[i] == FREE) && (elixir >= COST[i]) && !game_over;
      end
    end
  end

  assign cancel   = (fsm == HOLD) &&
                    (rclick || game_over || (lclick && card_hit && card_idx == sel_idx));
  assign spend_en = (fsm == HOLD) && !cancel && lclick && hit_field;

  elixir_bank u_bank (
    .Clk        (Clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .spend_en   (spend_en),
    .cost       (COST[sel_idx]),
    .elixir     (elixir)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      vsync_q    <= 1'b0;
      btn_q      <= '0;
      infield_q  <= '0;
      fsm        <= IDLE;
      sel_valid  <= 1'b0;
      sel_idx    <= '0;
      instateout <= '0;
      deployout  <= '0;
      for (int i = 0; i < NUM_UNITS; i++) slot[i] <= FREE_PEND;
    end else begin
      vsync_q   <= vsync;
      btn_q     <= button;
      infield_q <= infield;
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (slot[i] == FREE_PEND && frame_tick) slot[i] <= FREE;
        else if (slot[i] == BUSY && fall[i])    slot[i] <= FREE_PEND;
      end
      case (fsm)
        IDLE: if (lclick && card_ok) begin
          fsm        <= HOLD;
          sel_valid  <= 1'b1;
          sel_idx    <= card_idx;
          instateout <= unit_mask(card_idx);
        end
        HOLD: if (cancel) begin
          fsm        <= IDLE;
          sel_valid  <= 1'b0;
          instateout <= '0;
        end else if (lclick && card_ok) begin
          sel_idx    <= card_idx;
          instateout <= unit_mask(card_idx);
        end else if (spend_en) begin
          fsm           <= DEPLOY;
          sel_valid     <= 1'b0;
          instateout    <= '0;
          deployout     <= unit_mask(sel_idx);
          slot[sel_idx] <= BUSY;
        end
        DEPLOY: if (frame_tick) begin
          fsm       <= IDLE;
          deployout <= '0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
